// File: rtl/req_scan_if.sv
// Handshake bundle for req_scan_serializer: vector input channel and serial position output channel.
interface req_scan_if #(
    parameter int N     = 8,
    parameter int POS_W = $clog2(N)
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [POS_W-1:0] out_pos;
    logic             out_last;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_pos, out_last
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_pos, out_last
    );
endinterface

// File: rtl/req_scan_serializer.sv
// Serializes a multi-hot request vector into set-bit indices, highest first.
// Optional REQ_COUNT_EN adds the pend_cnt popcount output.
//
// state | meaning
// IDLE  | ready for a new vector, nothing pending
// EMIT  | presenting highest pending index until the last bit is handed off
module req_scan_serializer #(
    parameter int N     = 8,
    parameter int POS_W = $clog2(N)
) (
    input  logic       clk,
    input  logic       rst_n,
    req_scan_if.slave  bus,
    output logic       busy
`ifdef REQ_COUNT_EN
    ,
    output logic [POS_W:0] pend_cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [POS_W-1:0] top_pos;
    logic             one_left;

    // Ascending scan so the highest set bit wins; pending==0 yields 0.
    always_comb begin
        top_pos = '0;
        for (int i = 0; i < N; i++) begin
            if (pending_q[i]) top_pos = POS_W'(i);
        end
    end

    assign one_left = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_pos   = top_pos;
    assign bus.out_last  = one_left;
    assign busy          = (state_q == EMIT);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && (bus.in_vec != '0)) begin
                    pending_d = bus.in_vec;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    pending_d = pending_q & ~(N'(1) << top_pos);
                    if (one_left) state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

`ifdef REQ_COUNT_EN
    logic [POS_W:0] cnt_q, cnt_d;
    logic [POS_W:0] vec_pop;

    always_comb begin
        vec_pop = '0;
        for (int i = 0; i < N; i++) begin
            vec_pop = vec_pop + (POS_W + 1)'(bus.in_vec[i]);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == IDLE) && bus.in_valid && (bus.in_vec != '0)) begin
            cnt_d = vec_pop;
        end else if ((state_q == EMIT) && bus.out_ready) begin
            cnt_d = cnt_q - (POS_W + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign pend_cnt = cnt_q;
`endif

endmodule
